// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the memory/writeback stage: memory op encoding, FSM states,
// and the regfile control packet carried from execute.
package mem_wb_stage_pkg;

  localparam int unsigned N_BITS       = 32;
  localparam int unsigned RF_ADDR_BITS = 5;

  typedef enum logic [1:0] {
    MEM_NONE = 2'd0,
    MEM_LW   = 2'd1,
    MEM_SW   = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StWb   = 2'd3
  } mem_wb_state_t;

  typedef struct packed {
    logic                    wen;
    logic [RF_ADDR_BITS-1:0] waddr;
  } rf_ctrl_t;

  // x0 is hardwired and stores never write the regfile.
  function automatic logic rf_writes(mem_op_t op, rf_ctrl_t ctrl);
    return ctrl.wen && (ctrl.waddr != '0) && (op != MEM_SW);
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Execute -> memory/writeback result interface (valid/ready with data and control packet).
interface mem_wb_stage_if;
  import mem_wb_stage_pkg::*;

  logic              x_valid;
  logic              x_ready;
  logic [N_BITS-1:0] x_data;
  logic [N_BITS-1:0] x_store_data;
  mem_op_t           x_mem_op;
  rf_ctrl_t          x_rf_ctrl;

  modport master (
    output x_valid,
    output x_data,
    output x_store_data,
    output x_mem_op,
    output x_rf_ctrl,
    input  x_ready
  );

  modport slave (
    input  x_valid,
    input  x_data,
    input  x_store_data,
    input  x_mem_op,
    input  x_rf_ctrl,
    output x_ready
  );

endinterface

// File: rtl/mem_wb_stage_dmem_req_fsm.sv
// Sequencing of the data-memory request/response for the single instruction held
// in the stage. Request valid is a registered output so it cannot glitch.
module mem_wb_stage_dmem_req_fsm
  import mem_wb_stage_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_accept,
  input  mem_op_t       i_accept_op,
  input  mem_op_t       i_op_q,
  input  logic          i_req_ready,
  input  logic          i_resp_valid,
  output mem_wb_state_t o_state,
  output logic          o_req_valid,
  output logic          o_resp_fire
);

  mem_wb_state_t r_state;
  logic          r_req_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_req_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_accept && (i_accept_op != MEM_NONE)) begin
            r_state     <= StReq;
            r_req_valid <= 1'b1;
          end
        end
        StReq: begin
          if (i_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= (i_op_q == MEM_LW) ? StResp : StWb;
          end
        end
        StResp: begin
          if (i_resp_valid) begin
            r_state <= StWb;
          end
        end
        StWb: begin
          // A new instruction may be accepted on the retiring edge.
          if (i_accept && (i_accept_op != MEM_NONE)) begin
            r_state     <= StReq;
            r_req_valid <= 1'b1;
          end else begin
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_state     = r_state;
  assign o_req_valid = r_req_valid;
  assign o_resp_fire = (r_state == StResp) && i_resp_valid;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: holds one instruction, runs LW/SW through the data memory,
// retires results to the regfile and exposes forwarding / load-busy to decode.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  mem_wb_stage_if.slave           x_if,
  output logic                    o_dmem_req_valid,
  input  logic                    i_dmem_req_ready,
  output logic                    o_dmem_req_we,
  output logic [N_BITS-1:0]       o_dmem_req_addr,
  output logic [N_BITS-1:0]       o_dmem_req_wdata,
  input  logic                    i_dmem_resp_valid,
  input  logic [N_BITS-1:0]       i_dmem_resp_data,
  output logic                    o_rf_wen,
  output logic [RF_ADDR_BITS-1:0] o_rf_waddr,
  output logic [N_BITS-1:0]       o_rf_wdata,
  output logic                    o_fwd_valid,
  output logic [RF_ADDR_BITS-1:0] o_fwd_waddr,
  output logic [N_BITS-1:0]       o_fwd_data,
  output logic                    o_fwd_busy
);

  logic              r_valid;
  logic [N_BITS-1:0] r_data;
  logic [N_BITS-1:0] r_sdata;
  mem_op_t           r_op;
  rf_ctrl_t          r_ctrl;

  mem_wb_state_t w_state;
  logic          w_req_valid;
  logic          w_resp_fire;
  logic          w_retire;
  logic          w_ready;
  logic          w_accept;
  logic          w_writes;

  assign w_retire = ((w_state == StIdle) && r_valid && (r_op == MEM_NONE)) || (w_state == StWb);
  assign w_ready  = !r_valid || w_retire;
  assign w_accept = x_if.x_valid && w_ready;
  assign w_writes = rf_writes(r_op, r_ctrl);

  assign x_if.x_ready = w_ready;

  mem_wb_stage_dmem_req_fsm u_dmem_req_fsm (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_accept     (w_accept),
    .i_accept_op  (x_if.x_mem_op),
    .i_op_q       (r_op),
    .i_req_ready  (i_dmem_req_ready),
    .i_resp_valid (i_dmem_resp_valid),
    .o_state      (w_state),
    .o_req_valid  (w_req_valid),
    .o_resp_fire  (w_resp_fire)
  );

  // Accept and response capture are exclusive: accept needs IDLE/WB, capture needs RESP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sdata <= '0;
      r_op    <= MEM_NONE;
      r_ctrl  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= x_if.x_data;
      r_sdata <= x_if.x_store_data;
      r_op    <= x_if.x_mem_op;
      r_ctrl  <= x_if.x_rf_ctrl;
    end else begin
      if (w_retire) begin
        r_valid <= 1'b0;
      end
      if (w_resp_fire) begin
        r_data <= i_dmem_resp_data;
      end
    end
  end

  assign o_dmem_req_valid = w_req_valid;
  assign o_dmem_req_we    = w_req_valid && (r_op == MEM_SW);
  assign o_dmem_req_addr  = r_data;
  assign o_dmem_req_wdata = r_sdata;

  assign o_rf_wen   = w_retire && w_writes;
  assign o_rf_waddr = r_ctrl.waddr;
  assign o_rf_wdata = r_data;

  // Forward only once the value is final; an in-flight load reports busy instead.
  assign o_fwd_valid = r_valid && w_writes && ((r_op == MEM_NONE) || (w_state == StWb));
  assign o_fwd_waddr = r_ctrl.waddr;
  assign o_fwd_data  = r_data;
  assign o_fwd_busy  = r_valid && (r_op == MEM_LW) && (w_state != StWb);

  a_req_stable : assert property (
    @(posedge i_clk) disable iff (i_rst)
    (o_dmem_req_valid && !i_dmem_req_ready) |=>
      (o_dmem_req_valid && $stable(o_dmem_req_addr) && $stable(o_dmem_req_wdata) &&
       $stable(o_dmem_req_we))
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized ALU and
// load/store traffic against a reference data memory and regfile-write rule.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if x_if ();

  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_data;
  logic        fwd_busy;

  int checks = 0;
  int errors = 0;

  // Reference data memory: word contents by byte address.
  logic [31:0] ref_mem [logic [31:0]];

  mem_wb_stage dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .x_if              (x_if),
    .o_dmem_req_valid  (dmem_req_valid),
    .i_dmem_req_ready  (dmem_req_ready),
    .o_dmem_req_we     (dmem_req_we),
    .o_dmem_req_addr   (dmem_req_addr),
    .o_dmem_req_wdata  (dmem_req_wdata),
    .i_dmem_resp_valid (dmem_resp_valid),
    .i_dmem_resp_data  (dmem_resp_data),
    .o_rf_wen          (rf_wen),
    .o_rf_waddr        (rf_waddr),
    .o_rf_wdata        (rf_wdata),
    .o_fwd_valid       (fwd_valid),
    .o_fwd_waddr       (fwd_waddr),
    .o_fwd_data        (fwd_data),
    .o_fwd_busy        (fwd_busy)
  );

  function automatic logic [31:0] mem_read(logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return {a[15:0], 16'hB00C} ^ 32'h5A5A_0000;
  endfunction

  // An instruction writes the regfile iff enabled, not x0, and not a store.
  function automatic logic expect_write(mem_op_t op, logic wen, logic [4:0] rd);
    return wen && (rd != 5'd0) && (op != MEM_SW);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    x_if.x_valid      = 1'b0;
    x_if.x_data       = $urandom;
    x_if.x_store_data = $urandom;
    x_if.x_mem_op     = ($urandom % 2) ? MEM_LW : MEM_NONE;
    x_if.x_rf_ctrl    = rf_ctrl_t'($urandom);
  endtask

  task automatic drive_instr(mem_op_t op, logic [31:0] data, logic [31:0] sdata, logic wen,
                             logic [4:0] rd);
    x_if.x_valid         = 1'b1;
    x_if.x_data          = data;
    x_if.x_store_data    = sdata;
    x_if.x_mem_op        = op;
    x_if.x_rf_ctrl.wen   = wen;
    x_if.x_rf_ctrl.waddr = rd;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
    drive_idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (x_if.x_ready !== 1'b1) begin errors++;
      $display("FAIL reset_x_ready got=%b exp=1", x_if.x_ready); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++;
      $display("FAIL reset_req_valid got=%b exp=0", dmem_req_valid); end
    checks++; if (rf_wen !== 1'b0) begin errors++;
      $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
    checks++; if (fwd_valid !== 1'b0) begin errors++;
      $display("FAIL reset_fwd_valid got=%b exp=0", fwd_valid); end
    checks++; if (fwd_busy !== 1'b0) begin errors++;
      $display("FAIL reset_fwd_busy got=%b exp=0", fwd_busy); end
    checks++; if ({rf_wdata, fwd_waddr, dmem_req_we} !== '0) begin errors++;
      $display("FAIL reset_outputs_zero got=%h exp=0", {rf_wdata, fwd_waddr, dmem_req_we}); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_alu(logic [31:0] data, logic wen, logic [4:0] rd);
    logic exp;
    exp = expect_write(MEM_NONE, wen, rd);
    step();
    drive_instr(MEM_NONE, data, $urandom, wen, rd);
    @(negedge clk);
    checks++; if (x_if.x_ready !== 1'b1) begin errors++;
      $display("FAIL alu_accept_ready got=%b exp=1", x_if.x_ready); end
    step();
    drive_idle();
    @(negedge clk);
    checks++; if (rf_wen !== exp) begin errors++;
      $display("FAIL alu_rf_wen rd=%0d got=%b exp=%b", rd, rf_wen, exp); end
    checks++; if (fwd_valid !== exp) begin errors++;
      $display("FAIL alu_fwd_valid rd=%0d got=%b exp=%b", rd, fwd_valid, exp); end
    checks++; if (fwd_waddr !== rd) begin errors++;
      $display("FAIL alu_fwd_waddr got=%0d exp=%0d", fwd_waddr, rd); end
    if (exp) begin
      checks++; if (rf_waddr !== rd || rf_wdata !== data) begin errors++;
        $display("FAIL alu_rf_write got=x%0d<=%h exp=x%0d<=%h", rf_waddr, rf_wdata, rd, data); end
      checks++; if (fwd_data !== data) begin errors++;
        $display("FAIL alu_fwd_data got=%h exp=%h", fwd_data, data); end
    end
    checks++; if (fwd_busy !== 1'b0 || x_if.x_ready !== 1'b1) begin errors++;
      $display("FAIL alu_busy_ready got=%b%b exp=01", fwd_busy, x_if.x_ready); end
    step();
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0) begin errors++;
      $display("FAIL alu_single_write got=%b exp=0", rf_wen); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  rds [3];
    logic [31:0] vals[3];
    rds = '{5'd3, 5'd4, 5'd5};
    for (int i = 0; i < 3; i++) vals[i] = $urandom;
    for (int i = 0; i <= 3; i++) begin
      step();
      if (i < 3) drive_instr(MEM_NONE, vals[i], $urandom, 1'b1, rds[i]);
      else       drive_idle();
      @(negedge clk);
      checks++; if (x_if.x_ready !== 1'b1) begin errors++;
        $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, x_if.x_ready); end
      if (i > 0) begin
        checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== rds[i-1] || rf_wdata !== vals[i-1]) begin
          errors++;
          $display("FAIL b2b_write cyc=%0d got=%b x%0d<=%h exp=1 x%0d<=%h", i, rf_wen,
                   rf_waddr, rf_wdata, rds[i-1], vals[i-1]);
        end
      end
    end
    step();
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0) begin errors++;
      $display("FAIL b2b_drain got=%b exp=0", rf_wen); end
  endtask

  // One load/store through the memory, optionally with an ALU op waiting upstream.
  task automatic do_mem_op(mem_op_t op, logic [31:0] addr, logic [31:0] sdata, logic wen,
                           logic [4:0] rd, int req_wait, int resp_wait, logic queue_alu);
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic [31:0] exp_data;
    logic        exp;
    alu_rd   = 5'($urandom_range(1, 31));
    alu_data = $urandom;
    exp      = expect_write(op, wen, rd);
    exp_data = (op == MEM_LW) ? mem_read(addr) : addr;

    step();
    drive_instr(op, addr, sdata, wen, rd);
    @(negedge clk);
    checks++; if (x_if.x_ready !== 1'b1) begin errors++;
      $display("FAIL mem_accept_ready got=%b exp=1", x_if.x_ready); end

    for (int c = 0; c <= req_wait; c++) begin
      step();
      if (c == 0) begin
        if (queue_alu) drive_instr(MEM_NONE, alu_data, $urandom, 1'b1, alu_rd);
        else           drive_idle();
      end
      dmem_req_ready  = (c == req_wait);
      dmem_resp_valid = 1'($urandom % 2);
      dmem_resp_data  = $urandom;
      @(negedge clk);
      checks++;
      if (dmem_req_valid !== 1'b1 || dmem_req_addr !== addr || dmem_req_wdata !== sdata ||
          dmem_req_we !== (op == MEM_SW)) begin
        errors++;
        $display("FAIL mem_req cyc=%0d got=v%b a=%h d=%h we=%b exp=v1 a=%h d=%h we=%b", c,
                 dmem_req_valid, dmem_req_addr, dmem_req_wdata, dmem_req_we, addr, sdata,
                 (op == MEM_SW));
      end
      checks++;
      if (x_if.x_ready !== 1'b0 || fwd_busy !== (op == MEM_LW) || rf_wen !== 1'b0) begin
        errors++;
        $display("FAIL mem_req_stall cyc=%0d got=rdy%b busy%b wen%b exp=rdy0 busy%b wen0", c,
                 x_if.x_ready, fwd_busy, rf_wen, (op == MEM_LW));
      end
    end
    step();
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;

    if (op == MEM_LW) begin
      for (int c = 0; c < resp_wait; c++) begin
        if (c > 0) step();
        dmem_resp_valid = (c == resp_wait - 1);
        dmem_resp_data  = (c == resp_wait - 1) ? exp_data : $urandom;
        @(negedge clk);
        checks++;
        if (dmem_req_valid !== 1'b0 || x_if.x_ready !== 1'b0 || fwd_busy !== 1'b1 ||
            rf_wen !== 1'b0 || fwd_valid !== 1'b0) begin
          errors++;
          $display("FAIL mem_resp_wait cyc=%0d got=req%b rdy%b busy%b wen%b fwd%b exp=00100",
                   c, dmem_req_valid, x_if.x_ready, fwd_busy, rf_wen, fwd_valid);
        end
      end
      step();
    end

    // Writeback cycle; a stray response here must not disturb the result.
    dmem_resp_valid = 1'($urandom % 2);
    dmem_resp_data  = $urandom;
    @(negedge clk);
    checks++; if (rf_wen !== exp) begin errors++;
      $display("FAIL mem_wb_wen op=%0d got=%b exp=%b", op, rf_wen, exp); end
    if (exp) begin
      checks++; if (rf_waddr !== rd || rf_wdata !== exp_data) begin errors++;
        $display("FAIL mem_wb_data got=x%0d<=%h exp=x%0d<=%h", rf_waddr, rf_wdata, rd,
                 exp_data); end
    end
    checks++;
    if (fwd_valid !== exp || fwd_busy !== 1'b0 || x_if.x_ready !== 1'b1 ||
        dmem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mem_wb_flags got=fwd%b busy%b rdy%b req%b exp=fwd%b busy0 rdy1 req0",
               fwd_valid, fwd_busy, x_if.x_ready, dmem_req_valid, exp);
    end
    if (op == MEM_SW) ref_mem[addr] = sdata;

    step();
    drive_idle();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_wen !== queue_alu || (queue_alu && (rf_waddr !== alu_rd || rf_wdata !== alu_data)))
    begin
      errors++;
      $display("FAIL mem_follow_alu got=%b x%0d<=%h exp=%b x%0d<=%h", rf_wen, rf_waddr,
               rf_wdata, queue_alu, alu_rd, alu_data);
    end
  endtask

  task automatic test_lw();
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    do_mem_op(MEM_LW, 32'h100, 32'h0BAD_0BAD, 1'b1, 5'd7, 3, 2, 1'b0);
  endtask

  task automatic test_sw();
    do_mem_op(MEM_SW, 32'h104, 32'hCAFE_F00D, 1'b1, 5'd9, 1, 1, 1'b0);
    do_mem_op(MEM_LW, 32'h104, $urandom, 1'b1, 5'd11, 0, 1, 1'b1);
  endtask

  task automatic test_mem_random();
    for (int i = 0; i < 8; i++) begin
      mem_op_t     op;
      logic [31:0] addr;
      op   = ($urandom % 2) ? MEM_LW : MEM_SW;
      addr = 32'h100 + 32'(($urandom % 4) * 4);
      do_mem_op(op, addr, $urandom, 1'($urandom % 2), 5'($urandom), $urandom_range(0, 3),
                $urandom_range(1, 3), 1'($urandom % 2));
    end
  endtask

  task automatic test_reset_mid_resp();
    step();
    drive_instr(MEM_LW, 32'h200, 32'h0, 1'b1, 5'd9);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    step();
    drive_idle();
    @(negedge clk);
    checks++; if (dmem_req_valid !== 1'b1) begin errors++;
      $display("FAIL rstmid_req got=%b exp=1", dmem_req_valid); end
    step();
    dmem_req_ready = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    checks++; if (fwd_busy !== 1'b1) begin errors++;
      $display("FAIL rstmid_in_resp got=%b exp=1", fwd_busy); end
    step();
    rst             = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h1111_1111;
    @(negedge clk);
    checks++;
    if (x_if.x_ready !== 1'b1 || fwd_busy !== 1'b0 || rf_wen !== 1'b0 ||
        dmem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after got=rdy%b busy%b wen%b req%b exp=rdy1 busy0 wen0 req0",
               x_if.x_ready, fwd_busy, rf_wen, dmem_req_valid);
    end
    step();
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_wen !== 1'b0 || fwd_valid !== 1'b0 || x_if.x_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_late_resp got=wen%b fwd%b rdy%b exp=wen0 fwd0 rdy1", rf_wen,
               fwd_valid, x_if.x_ready);
    end
    test_alu(32'h0F0F_1234, 1'b1, 5'd12);
  endtask

  initial begin
    test_reset();
    test_alu(32'h1234_5678, 1'b1, 5'd5);
    test_back_to_back();
    test_alu($urandom, 1'b1, 5'd0);
    for (int i = 0; i < 6; i++) test_alu($urandom, 1'($urandom % 2), 5'($urandom));
    test_lw();
    test_sw();
    test_mem_random();
    test_reset_mid_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
